// File: rtl/control_sequencer.sv
// Five-step (T0..T4) microcode sequencer for an 8-bit bus CPU; control lines decode combinationally.
// Define COND_JUMP_EN to decode JC/JZ; otherwise 0110/0111 behave as NOP.
module control_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       CF,
   input  logic       ZF,
   output logic       pc_en,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       mar_load,
   output logic       ram_en,
   output logic       ram_load,
   output logic       ir_load,
   output logic       ir_en,
   output logic       a_load,
   output logic       a_en,
   output logic       b_load,
   output logic       out_load,
   output logic       alu_en,
   output logic       alu_sub,
   output logic       halted,
   output logic [2:0] step
);

   typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_e;

   step_e step_q, step_d;
   logic  halted_q, halted_d;
   logic  armed_q;

   // armed_q holds T0 for one full clock after reset release so T0 is never a partial cycle.
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q   <= T0;
         halted_q <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
         armed_q  <= 1'b1;
      end
   end

   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (!halted_q && armed_q) begin
         if (step_q == T2 && opcode == 4'hF) begin
            halted_d = 1'b1;
         end else if (step_q == T4) begin
            step_d = T0;
         end else begin
            step_d = step_e'(step_q + 3'd1);
         end
      end
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      pc_en    = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      mar_load = 1'b0;
      ram_en   = 1'b0;
      ram_load = 1'b0;
      ir_load  = 1'b0;
      ir_en    = 1'b0;
      a_load   = 1'b0;
      a_en     = 1'b0;
      b_load   = 1'b0;
      out_load = 1'b0;
      alu_en   = 1'b0;
      alu_sub  = 1'b0;
      if (!rst && !halted_q) begin
         case (step_q)
            T0: begin
               pc_en    = 1'b1;
               mar_load = 1'b1;
            end
            T1: begin
               ram_en  = 1'b1;
               ir_load = 1'b1;
               pc_inc  = 1'b1;
            end
            T2: begin
               case (opcode)
                  4'h0, 4'h1, 4'h2, 4'h3: begin
                     ir_en    = 1'b1;
                     mar_load = 1'b1;
                  end
                  4'h4: begin
                     ir_en  = 1'b1;
                     a_load = 1'b1;
                  end
                  4'h5: begin
                     ir_en   = 1'b1;
                     pc_load = 1'b1;
                  end
`ifdef COND_JUMP_EN
                  4'h6: begin
                     ir_en   = CF;
                     pc_load = CF;
                  end
                  4'h7: begin
                     ir_en   = ZF;
                     pc_load = ZF;
                  end
`endif
                  4'hE: begin
                     a_en     = 1'b1;
                     out_load = 1'b1;
                  end
                  default: ;
               endcase
            end
            T3: begin
               case (opcode)
                  4'h0: begin
                     ram_en = 1'b1;
                     a_load = 1'b1;
                  end
                  4'h1, 4'h2: begin
                     ram_en = 1'b1;
                     b_load = 1'b1;
                  end
                  4'h3: begin
                     a_en     = 1'b1;
                     ram_load = 1'b1;
                  end
                  default: ;
               endcase
            end
            T4: begin
               if (opcode == 4'h1 || opcode == 4'h2) begin
                  alu_en  = 1'b1;
                  a_load  = 1'b1;
                  alu_sub = (opcode == 4'h2);
               end
            end
            default: ;
         endcase
      end
   end

`ifndef COND_JUMP_EN
   // Flags only matter for conditional jumps; consume them so the NOP build stays lint-clean.
   logic unused_flags;
   assign unused_flags = CF ^ ZF;
`endif

   assign halted = halted_q;
   assign step   = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against an opcode-table reference model.
module tb_control_sequencer;

   typedef struct packed {
      logic pc_en, pc_inc, pc_load, mar_load, ram_en, ram_load, ir_load;
      logic ir_en, a_load, a_en, b_load, out_load, alu_en, alu_sub;
   } ctrl_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic       CF = 1'b0, ZF = 1'b0;
   logic       pc_en, pc_inc, pc_load, mar_load, ram_en, ram_load, ir_load;
   logic       ir_en, a_load, a_en, b_load, out_load, alu_en, alu_sub;
   logic       halted;
   logic [2:0] step;

   int checks = 0;
   int failures = 0;

   // Reference model state.
   int exp_step;
   bit exp_halted;
   int edges_since_release;

   control_sequencer dut (
      .clk(clk), .rst(rst), .opcode(opcode), .CF(CF), .ZF(ZF),
      .pc_en(pc_en), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
      .ram_en(ram_en), .ram_load(ram_load), .ir_load(ir_load), .ir_en(ir_en),
      .a_load(a_load), .a_en(a_en), .b_load(b_load), .out_load(out_load),
      .alu_en(alu_en), .alu_sub(alu_sub), .halted(halted), .step(step)
   );

   always #5 clk = ~clk;

   ctrl_t dut_ctrl;
   assign dut_ctrl = '{pc_en, pc_inc, pc_load, mar_load, ram_en, ram_load, ir_load,
                       ir_en, a_load, a_en, b_load, out_load, alu_en, alu_sub};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected control word, organised per instruction as the opcode table reads.
   function automatic ctrl_t model_ctrl(input int s, input logic [3:0] op, input logic cf,
                                        input logic zf, input bit hlt);
      ctrl_t c = '0;
      bit    cond_en;
`ifdef COND_JUMP_EN
      cond_en = 1'b1;
`else
      cond_en = 1'b0;
`endif
      if (hlt) return c;
      if (s == 0) begin
         c.pc_en = 1; c.mar_load = 1;
         return c;
      end
      if (s == 1) begin
         c.ram_en = 1; c.ir_load = 1; c.pc_inc = 1;
         return c;
      end
      case (op)
         4'h0: if (s == 2) begin c.ir_en = 1; c.mar_load = 1; end
               else if (s == 3) begin c.ram_en = 1; c.a_load = 1; end
         4'h1, 4'h2: if (s == 2) begin c.ir_en = 1; c.mar_load = 1; end
                     else if (s == 3) begin c.ram_en = 1; c.b_load = 1; end
                     else begin c.alu_en = 1; c.a_load = 1; c.alu_sub = (op == 4'h2); end
         4'h3: if (s == 2) begin c.ir_en = 1; c.mar_load = 1; end
               else if (s == 3) begin c.a_en = 1; c.ram_load = 1; end
         4'h4: if (s == 2) begin c.ir_en = 1; c.a_load = 1; end
         4'h5: if (s == 2) begin c.ir_en = 1; c.pc_load = 1; end
         4'h6: if (s == 2 && cond_en && cf) begin c.ir_en = 1; c.pc_load = 1; end
         4'h7: if (s == 2 && cond_en && zf) begin c.ir_en = 1; c.pc_load = 1; end
         4'hE: if (s == 2) begin c.a_en = 1; c.out_load = 1; end
         default: ;
      endcase
      return c;
   endfunction

   // Assert reset at the current time, verify the reset state, release on the next falling edge.
   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check("rst_ctrl", dut_ctrl, '0);
      check("rst_step", step, 0);
      check("rst_halted", halted, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_step = 0;
      exp_halted = 0;
      edges_since_release = 0;
   endtask

   // Called on a falling edge: drive inputs, compare outputs against the model.
   task automatic drive_check(input logic [3:0] op, input logic cf, input logic zf);
      ctrl_t exp_c;
      int    drivers;
      opcode = op;
      CF = cf;
      ZF = zf;
      #1;
      exp_c = model_ctrl(exp_step, op, cf, zf, exp_halted);
      check("step", step, exp_step);
      check("halted", halted, exp_halted);
      check("ctrl", dut_ctrl, exp_c);
      drivers = int'(pc_en) + int'(ram_en) + int'(ir_en) + int'(a_en) + int'(alu_en);
      check("bus_drivers_le1", drivers <= 1, 1);
   endtask

   // Step the model across one rising edge and return on the next falling edge.
   task automatic advance();
      @(posedge clk);
      if (!exp_halted) begin
         if (edges_since_release == 0) begin
            edges_since_release = 1;
         end else if (exp_step == 2 && opcode == 4'hF) begin
            exp_halted = 1;
         end else begin
            exp_step = (exp_step + 1) % 5;
         end
      end
      @(negedge clk);
   endtask

   task automatic cycle(input logic [3:0] op, input logic cf, input logic zf);
      drive_check(op, cf, zf);
      advance();
   endtask

   initial begin
      int         halt_cycles;
      logic [3:0] rop;

      @(negedge clk);
      @(negedge clk);
      apply_reset();

      // LDA: two T0 cycles after release, then T1..T4 and back to T0.
      for (int i = 0; i < 7; i++) cycle(4'h0, 1'b0, 1'b0);

      // SUB and ADD with flags toggling.
      for (int i = 0; i < 5; i++) cycle(4'h2, i[0], ~i[0]);
      for (int i = 0; i < 5; i++) cycle(4'h1, 1'b1, 1'b1);

      // Conditional jumps with each flag value.
      for (int i = 0; i < 5; i++) cycle(4'h6, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(4'h6, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(4'h7, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(4'h7, 1'b1, 1'b0);

      // Asynchronous reset in T3 of ADD.
      while (exp_step != 0) cycle(4'h1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(4'h1, 1'b0, 1'b0);
      drive_check(4'h1, 1'b0, 1'b0);
      check("add_in_t3", step, 3);
      #1;
      apply_reset();
      for (int i = 0; i < 6; i++) cycle(4'h1, 1'b0, 1'b0);

      // Halt: freezes at step 2 with all controls low for 20+ cycles, then reset.
      apply_reset();
      for (int i = 0; i < 26; i++) cycle(4'hF, 1'b0, 1'b0);
      check("halted_hold", halted, 1);
      #2;
      apply_reset();
      for (int i = 0; i < 3; i++) cycle(4'h0, 1'b0, 1'b0);

      // Random instruction stream (~1000 instructions); recover from HLT with a reset.
      halt_cycles = 0;
      rop = 4'h0;
      for (int i = 0; i < 5200; i++) begin
         if (exp_step == 0 && !exp_halted) rop = 4'($urandom_range(15, 0));
         cycle(rop, 1'($urandom), 1'($urandom));
         if (exp_halted) halt_cycles++;
         if (halt_cycles > 3) begin
            halt_cycles = 0;
            #2;
            apply_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: opcode  in  4  upper nibble of instruction register.
REQ-004 SHALL have ports: CF, ZF  in  1 each  registered flags from ALU.
REQ-005 SHALL have ports: pc_en, pc_inc, pc_load  out  1 each  PC drives bus / increments / loads from bus.
REQ-006 SHALL have ports: mar_load, ram_en, ram_load  out  1 each  MAR load / RAM drives bus / RAM write.
REQ-007 SHALL have ports: ir_load, ir_en  out  1 each  IR load / IR low nibble drives bus.
REQ-008 SHALL have ports: a_load, a_en, b_load, out_load  out  1 each  register A load / A drives bus / B load / output register load.
REQ-009 SHALL have ports: alu_en, alu_sub  out  1 each  ALU enable_output / ALU sub select.
REQ-010 SHALL have ports: halted  out  1  CPU stopped; step  out  3  current T-state, debug.

Function
REQ-011 SHALL hold a step counter cycling T0..T4 (0..4), advancing once per clk, wrapping 4->0; every instruction takes exactly 5 cycles.
REQ-012 SHALL drive all control outputs as combinational decode of step, opcode, CF, ZF; only step and halted are registered.
REQ-013 SHALL drive in T0: pc_en, mar_load.
REQ-014 SHALL drive in T1: ram_en, ir_load, pc_inc; opcode is valid from T2.
REQ-015 SHALL decode T2..T4 (unlisted steps idle):
  - LDA 0000: T2 ir_en+mar_load; T3 ram_en+a_load.
  - ADD 0001: T2 ir_en+mar_load; T3 ram_en+b_load; T4 alu_en+a_load, alu_sub=0.
  - SUB 0010: as ADD, T4 alu_sub=1.
  - STA 0011: T2 ir_en+mar_load; T3 a_en+ram_load.
  - LDI 0100: T2 ir_en+a_load.
  - JMP 0101: T2 ir_en+pc_load.
  - JC 0110 / JZ 0111: T2 ir_en+pc_load only when CF=1 / ZF=1, else idle.
  - OUT 1110: T2 a_en+out_load.
  - HLT 1111: T2 sets halted at clock edge ending T2.
  - all other opcodes: NOP, T2..T4 idle.
REQ-016 SHALL never assert more than one of pc_en, ram_en, ir_en, a_en, alu_en in the same cycle.
REQ-017 SHALL keep alu_sub=0 in every cycle except SUB T4.
REQ-018 SHALL, once halted=1, freeze step and force all control outputs to 0 until rst.
REQ-019 SHALL sample CF/ZF combinationally during T2 only; flags from a preceding ADD/SUB T4 are visible.

Reset
REQ-020 SHALL, while rst=1, force step=0, halted=0, all control outputs 0, regardless of clk.
REQ-021 SHALL, on first rising clk after rst deasserts, remain in T0 with T0 outputs active, advancing to T1 on the following edge.
REQ-022 SHALL abort any instruction when rst asserts mid-step; no partial completion after release.

Configuration
REQ-023 SHALL, when COND_JUMP_EN is defined, implement JC and JZ per REQ-015.
REQ-024 SHALL, when COND_JUMP_EN is undefined, decode 0110 and 0111 as NOP and ignore CF/ZF.

Verification
REQ-025 Reset release, opcode=0000 -> step 0,1,2,3,4,0; T0 pc_en=mar_load=1; T1 ram_en=ir_load=pc_inc=1.
REQ-026 opcode=0010 -> T4: alu_en=1, alu_sub=1, a_load=1; alu_sub=0 in T0..T3.
REQ-027 opcode=0110 with CF=1 -> T2 pc_load=1; CF=0 -> pc_load=0; without COND_JUMP_EN -> pc_load=0 both cases.
REQ-028 opcode=1111 -> halted=1 after T2; step stays 2 and all controls 0 for 20 cycles; rst pulse -> halted=0, step=0.
REQ-029 rst asserted asynchronously in T3 of ADD -> outputs 0 immediately; after release sequence restarts at T0.
REQ-030 Random opcodes/flags, 1000 instructions -> no cycle with two bus drivers; unlisted opcodes show idle T2..T4.
